// File: rtl/csa_pkg.sv
// Shared sizing for the CSA resolver: vector width, chunk size and derived stage count.
// Latency and backpressure live in csa_resolve_pipe; this package only carries constants and types.
package csa_pkg;
  localparam int CSA_WIDTH   = 63;
  localparam int CPA_CHUNK   = 16;
  localparam int CPA_NSTAGES = (CSA_WIDTH + CPA_CHUNK - 1) / CPA_CHUNK;

  typedef logic [CSA_WIDTH-1:0] csa_vec_t;
endpackage

// File: rtl/cpa_stage.sv
// One registered chunk of the carry-propagate adder; 1-cycle latency.
// Captures new data only when the parent asserts load, so a stalled stage keeps its contents.
module cpa_stage
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int LO    = 0,
  parameter int W     = CPA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic             cin,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             valid,
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [W:0]       chunk;
  logic [WIDTH-1:0] sum_next;

  // The resolved chunk overwrites its slice of the sum vector; upper slices pass through untouched.
  always_comb begin
    chunk    = {1'b0, in_sum[LO +: W]} + {1'b0, in_carry[LO +: W]} + {{W{1'b0}}, cin};
    sum_next = in_sum;
    sum_next[LO +: W] = chunk[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (load && in_valid) begin
      sum   <= sum_next;
      carry <= in_carry;
      cout  <= chunk[W];
    end
  end

endmodule

// File: rtl/csa_resolve_pipe.sv
// Resolves a CSA sum/carry pair to binary in NSTAGES chunked stages; latency NSTAGES, one result per cycle.
// Valid/ready with bubble collapse; in_ready follows out_ready combinationally. CSA_RESOLVE_COUT_EN adds out_cout.
module csa_resolve_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CHUNK = CPA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef CSA_RESOLVE_COUT_EN
  ,
  output logic             out_cout
`endif
);

  localparam int NSTAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST_W  = WIDTH - (NSTAGES - 1) * CHUNK;

  // Index 0 is the pipe input; index k+1 is the output of stage k.
  logic [NSTAGES:0] pipe_valid;
  logic [NSTAGES:0] pipe_cout;
  logic [WIDTH-1:0] pipe_sum   [NSTAGES+1];
  logic [WIDTH-1:0] pipe_carry [NSTAGES+1];
  logic [NSTAGES:0] load;

  assign pipe_valid[0] = in_valid;
  assign pipe_cout[0]  = 1'b0;
  assign pipe_sum[0]   = in_sum;
  assign pipe_carry[0] = in_carry;

  // A stage may load if it is empty or its successor is taking its contents this cycle.
  always_comb begin
    load          = '0;
    load[NSTAGES] = out_ready;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      load[k] = !pipe_valid[k+1] || load[k+1];
    end
  end

  assign in_ready = load[0] && !rst;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int STAGE_W = (k == NSTAGES - 1) ? LAST_W : CHUNK;

    cpa_stage #(
      .WIDTH (WIDTH),
      .LO    (k * CHUNK),
      .W     (STAGE_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .in_valid (pipe_valid[k]),
      .cin      (pipe_cout[k]),
      .in_sum   (pipe_sum[k]),
      .in_carry (pipe_carry[k]),
      .valid    (pipe_valid[k+1]),
      .cout     (pipe_cout[k+1]),
      .sum      (pipe_sum[k+1]),
      .carry    (pipe_carry[k+1])
    );
  end

  // Datapath registers are unreset, so outputs are masked whenever nothing valid is presented.
  assign out_valid  = pipe_valid[NSTAGES] && !rst;
  assign out_result = out_valid ? pipe_sum[NSTAGES] : '0;

  logic [WIDTH-1:0] carry_unused;
  assign carry_unused = pipe_carry[NSTAGES];

`ifdef CSA_RESOLVE_COUT_EN
  assign out_cout = out_valid && pipe_cout[NSTAGES];
`else
  logic cout_unused;
  assign cout_unused = pipe_cout[NSTAGES];
`endif

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Bench for csa_resolve_pipe: directed vector table, hand sequences for stall/full/reset,
// and a randomized phase scored against an arithmetic reference queue.
module tb_csa_resolve_pipe;
  import csa_pkg::*;

  localparam int N = CPA_NSTAGES;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid;
  logic     in_ready;
  csa_vec_t in_sum;
  csa_vec_t in_carry;
  logic     out_valid;
  logic     out_ready;
  csa_vec_t out_result;
`ifdef CSA_RESOLVE_COUT_EN
  logic     out_cout;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csa_resolve_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef CSA_RESOLVE_COUT_EN
    ,
    .out_cout   (out_cout)
`endif
  );

  typedef struct {
    csa_vec_t r;
    logic     co;
  } res_t;

  typedef struct {
    csa_vec_t s;
    csa_vec_t c;
    csa_vec_t r;
    logic     co;
  } vec_t;

  res_t     exp_q[$];
  bit       stall_prev = 1'b0;
  csa_vec_t held_r;
  logic     held_co;
  int       handoffs = 0;
  int       accepts  = 0;

  function automatic res_t model(input csa_vec_t s, input csa_vec_t c);
    logic [CSA_WIDTH:0] full;
    res_t m;
    full = {1'b0, s} + {1'b0, c};
    m.r  = full[CSA_WIDTH-1:0];
    m.co = full[CSA_WIDTH];
    return m;
  endfunction

  function automatic csa_vec_t rnd_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[62:0];
  endfunction

  function automatic csa_vec_t rnd_carry();
    csa_vec_t v;
    v    = rnd_vec();
    v[0] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: pops on every handoff, pushes on every transfer, and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_result", {1'b0, out_result}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    end else begin
      if (stall_prev && out_valid) begin
        chk("stall_hold_result", {1'b0, out_result}, {1'b0, held_r});
`ifdef CSA_RESOLVE_COUT_EN
        chk("stall_hold_cout", {63'd0, out_cout}, {63'd0, held_co});
`endif
      end
      if (out_valid && out_ready) begin
        handoffs++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got %h with no item outstanding", out_result);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb_result", {1'b0, out_result}, {1'b0, e.r});
`ifdef CSA_RESOLVE_COUT_EN
          chk("sb_cout", {63'd0, out_cout}, {63'd0, e.co});
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sum, in_carry));
        accepts++;
      end
      stall_prev = out_valid && !out_ready;
      held_r     = out_result;
`ifdef CSA_RESOLVE_COUT_EN
      held_co    = out_cout;
`else
      held_co    = 1'b0;
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    int          lat;
    int          a0;
    int          h0;
    logic [31:0] ov;

    tbl[0] = '{s: 63'h7FFF_FFFF_FFFF_FFFF, c: 63'd1,                   r: 63'd0,                   co: 1'b1};
    tbl[1] = '{s: 63'd4,                   c: 63'd14,                  r: 63'd18,                  co: 1'b0};
    tbl[2] = '{s: 63'd0,                   c: 63'd0,                   r: 63'd0,                   co: 1'b0};
    tbl[3] = '{s: 63'h0000_0000_0000_FFFF, c: 63'd2,                   r: 63'h0000_0000_0001_0001, co: 1'b0};
    tbl[4] = '{s: 63'h7FFF_0000_0000_0000, c: 63'h0001_0000_0000_0000, r: 63'd0,                   co: 1'b1};
    tbl[5] = '{s: 63'h5555_5555_5555_5555, c: 63'h2AAA_AAAA_AAAA_AAAA, r: 63'h7FFF_FFFF_FFFF_FFFF, co: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    repeat (2) next_cycle();
    mid();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_result", {1'b0, out_result}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Directed vectors, one at a time, with latency measured from the transfer cycle.
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      next_cycle();
      in_valid = 1'b1;
      in_sum   = tbl[i].s;
      in_carry = tbl[i].c;
      mid();
      chk("tbl_accept", {63'd0, in_ready}, 64'd1);
      next_cycle();
      in_valid = 1'b0;
      in_sum   = rnd_vec();
      in_carry = rnd_carry();
      mid();
      lat = 1;
      while (!out_valid && lat < 20) begin
        next_cycle();
        mid();
        lat++;
      end
      chk("tbl_latency", 64'(lat), 64'(N));
      chk("tbl_result", {1'b0, out_result}, {1'b0, tbl[i].r});
`ifdef CSA_RESOLVE_COUT_EN
      chk("tbl_cout", {63'd0, out_cout}, {63'd0, tbl[i].co});
`endif
    end
    repeat (3) next_cycle();

    // Eight back-to-back pairs: results must appear on eight consecutive cycles, N after the first.
    ov = '0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      in_valid = (c < 8);
      in_sum   = rnd_vec();
      in_carry = rnd_carry();
      mid();
      if (c < 8) chk("burst_accept", {63'd0, in_ready}, 64'd1);
      ov[c] = out_valid;
    end
    chk("burst_out_pattern", {32'd0, ov}, {32'd0, 32'h0000_0FF0});

    // Consumer stalled for 10 cycles with a producer always offering.
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mid();
    a0 = accepts;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      in_valid = 1'b1;
      in_sum   = rnd_vec();
      in_carry = rnd_carry();
      mid();
    end
    chk("full_accepts", 64'(accepts - a0), 64'd4);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    h0 = handoffs;
    repeat (N + 4) begin
      mid();
      next_cycle();
    end
    chk("drain_count", 64'(handoffs - h0), 64'd4);

    // Refill, then push and pop together on a full pipe for three cycles.
    out_ready = 1'b0;
    for (int c = 0; c < N; c++) begin
      in_valid = 1'b1;
      in_sum   = rnd_vec();
      in_carry = rnd_carry();
      mid();
      next_cycle();
    end
    h0 = handoffs;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_sum   = rnd_vec();
      in_carry = rnd_carry();
      mid();
      chk("full_pass_ready", {63'd0, in_ready}, 64'd1);
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (N + 4) begin
      mid();
      next_cycle();
    end
    chk("pass_drain_count", 64'(handoffs - h0), 64'd7);

    // Reset with three items in flight: none of them may ever emerge.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_sum   = rnd_vec();
      in_carry = rnd_carry();
      mid();
      next_cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    h0       = handoffs;
    mid();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("midrst_ready_after", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid_after", {63'd0, out_valid}, 64'd0);
    repeat (10) begin
      next_cycle();
      mid();
    end
    chk("midrst_no_emit", 64'(handoffs - h0), 64'd0);
    next_cycle();
    in_valid = 1'b1;
    in_sum   = tbl[1].s;
    in_carry = tbl[1].c;
    mid();
    chk("midrst_new_accept", {63'd0, in_ready}, 64'd1);
    next_cycle();
    in_valid = 1'b0;
    mid();
    lat = 1;
    while (!out_valid && lat < 20) begin
      next_cycle();
      mid();
      lat++;
    end
    chk("midrst_new_latency", 64'(lat), 64'(N));
    chk("midrst_new_result", {1'b0, out_result}, {1'b0, tbl[1].r});

    // Random traffic on both sides, scored by the reference queue.
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sum    = rnd_vec();
      in_carry  = rnd_carry();
    end
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (N + 6) next_cycle();
    mid();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_out_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_resolve_pipe.md
CSA_RESOLVE_PIPE -- requirements
Module: csa_resolve_pipe

Interface
REQ-001 Parameter WIDTH, default 63: operand and result width; matches the CSA vector width.
REQ-002 Parameter CHUNK, default 16: bits resolved per pipeline stage; NSTAGES = ceil(WIDTH/CHUNK), which is 4 by default.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  SUM/CARRY pair presented.
REQ-006 in_ready  output  1  pipeline can accept this cycle.
REQ-007 in_sum  input  WIDTH  CSA SUM vector.
REQ-008 in_carry  input  WIDTH  CSA CARRY vector, already left-shifted with bit 0 = 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_result  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
REQ-012 out_cout  output  1  bit WIDTH of the full sum; present only under REQ-030.

Function
REQ-013 A transfer occurs on a cycle where in_valid && in_ready; output handoff occurs on a cycle where out_valid && out_ready.
REQ-014 Stage k (k = 0..NSTAGES-1) adds bits [k*CHUNK +: CHUNK] of sum and carry plus the carry registered by stage k-1 (0 for k=0); it registers the partial result, the chunk carry, and the not-yet-resolved upper operand bits.
REQ-015 Last stage width = WIDTH - (NSTAGES-1)*CHUNK (15 bits by default); its carry out is the full carry-out.
REQ-016 Latency: with out_ready held high, out_valid rises exactly NSTAGES cycles after the transfer cycle.
REQ-017 Each stage holds a valid bit; stage k loads when it is empty, or when stage k+1 loads, or (last stage) on an output handoff.
REQ-018 in_ready = stage-0 load condition; it may depend combinationally on out_ready; bubbles collapse.
REQ-019 Throughput: one result per cycle under continuous in_valid and out_ready.
REQ-020 Stall: while out_valid && !out_ready, out_result and out_cout hold stable and no stage holding valid data is overwritten.
REQ-021 Full: after NSTAGES accepted items with out_ready low, in_ready = 0.
REQ-022 Simultaneous handoff and transfer on a full pipeline are allowed; occupancy is unchanged.
REQ-023 Ordering: results leave in acceptance order; no drops, no duplicates.
REQ-024 Inputs are sampled only on the transfer cycle; in_sum/in_carry are don't-care otherwise.

Reset
REQ-025 While rst is high: all stage valid bits clear, out_valid = 0, out_result = 0, out_cout = 0.
REQ-026 in_ready = 0 while rst is high, and 1 on the first cycle after rst falls.
REQ-027 Reset mid-operation discards all in-flight data; nothing is emitted afterwards for those items.
REQ-028 Datapath registers other than valid bits may be left unreset internally, but outputs are forced to 0 while !out_valid.

Configuration
REQ-029 Macro CSA_RESOLVE_COUT_EN controls the carry-out feature.
REQ-030 With CSA_RESOLVE_COUT_EN defined: out_cout port exists and carries the final-stage carry, aligned with out_result.
REQ-031 Without CSA_RESOLVE_COUT_EN: port absent, final carry discarded, all other behaviour identical.

Structure
REQ-032 Shared package csa_pkg holds CSA_WIDTH = 63, CPA_CHUNK = 16, the derived CPA_NSTAGES, and the operand vector typedef.
REQ-033 One sub-module, cpa_stage: a single registered chunk adder with valid/load, instantiated NSTAGES times via generate.
REQ-034 No combinational path from in_sum/in_carry to outputs; the only combinational path permitted is out_ready to in_ready.

Verification
REQ-035 in_sum = 63'h7FFF_FFFF_FFFF_FFFF, in_carry = 1, out_ready = 1 -> after 4 cycles out_result = 0, out_cout = 1.
REQ-036 CSA vectors for A = 5, B = 6, C = 7 (sum = 4, carry = 14) -> out_result = 18, out_cout = 0.
REQ-037 8 back-to-back random pairs, out_ready = 1 -> 8 results on consecutive cycles, in order, matching a golden model.
REQ-038 out_ready low 10 cycles with in_valid high -> exactly 4 accepted, in_ready = 0 thereafter, out_result stable; release -> 4 correct results drain.
REQ-039 rst pulsed with 3 items in flight -> out_valid = 0 the next cycle, none of those 3 items ever appear, new input is accepted after reset.
REQ-040 Build without CSA_RESOLVE_COUT_EN and rerun REQ-035 -> out_result = 0 and the port is absent.
